irq_sb_ctrl: RTL and testbench
==============================

Name: irq_sb_ctrl

Overview:
Interrupt controller that shares the single core interrupt line between up to N peripheral controllers (PS/2, UART, timer, ...). It sits between the peripherals' request/return pairs and the core's interrupt request/return pair. It arbitrates among pending sources, sequences the request → service → return handshake, and routes the return pulse back only to the serviced source. Mask and status registers are exposed on the system bus.

Parameters:
N_SRC, 4, number of interrupt sources (1..16); source index 0 has highest fixed priority

Ports:
clk_i  input  1  processor clock
rst_i  input  1  synchronous active-high reset
addr_i  input  32  system bus byte address (block-relative)
req_i  input  1  bus request
write_data_i  input  32  bus write data
write_enable_i  input  1  1 = write, 0 = read
read_data_o  output  32  registered read data
src_irq_i  input  N_SRC  level interrupt requests from peripherals
src_ret_o  output  N_SRC  one-cycle return pulse to the serviced peripheral
core_irq_o  output  1  interrupt request to the core
core_irq_ret_i  input  1  interrupt return (mret) from the core
core_cause_o  output  32  cause of the active interrupt

Behaviour:
- Clock and reset: one clock, clk_i; reset is synchronous and active-high (rst_i).
- Register map, word addresses:
  - 0x00 MASK: RW; only the low N_SRC bits are stored; 1 = enabled.
  - 0x04 PENDING: RO; src_irq_i & MASK.
  - 0x08 ACTIVE: RO; {valid at bit 31, sel in bits 3:0}.
  - 0x24 RESET: WO; writing exactly 32'h1 acts as a soft reset, equivalent to rst_i; any other value is ignored.
- Bus reads:
  - read_data_o updates one cycle after a read request to 0x00, 0x04 or 0x08.
  - Otherwise read_data_o holds its value; unmapped reads hold.
  - Writes to RO or unmapped addresses are ignored.
- Reset values: MASK = all ones; read_data_o = 0; core_irq_o = 0; src_ret_o = 0; core_cause_o = 0; state = IDLE; sel = 0; rr_ptr = 0.
- FSM (all outputs registered):
  - IDLE: if PENDING ≠ 0, latch sel from the priority encoder, go to ACTIVE. core_irq_o rises and core_cause_o = 32'h8000_0010 | sel one cycle after PENDING is first seen nonzero.
  - ACTIVE: core_irq_o held at 1; no preemption; changes on src_irq_i and MASK writes do not alter sel. On core_irq_ret_i = 1, go to RETURN.
  - RETURN: core_irq_o = 0; src_ret_o = one-hot(sel) for exactly one cycle; go to IDLE. core_cause_o clears to 0.
- Boundary conditions:
  - core_irq_ret_i in IDLE or RETURN is ignored.
  - A source that drops its request while ACTIVE (e.g. firmware read the data register) is still completed normally, including its return pulse.
  - The earliest re-arbitration is the IDLE cycle after RETURN. The source clears its request on the return edge, so it is not re-selected spuriously.
  - Simultaneous requests: the priority encoder picks the winner; losers stay pending.
  - Soft reset or rst_i in ACTIVE/RETURN forces IDLE with no return pulse; MASK returns to all ones.
  - Bus access and FSM progress are independent in the same cycle; a MASK write takes effect at the next IDLE evaluation.
- Latency: request to core_irq_o = 1 cycle; core_irq_ret_i to src_ret_o = 1 cycle.

Optional Feature:
IRQ_SB_CTRL_ROUND_ROBIN_EN
- Defined: rotating priority. The search starts at rr_ptr and wraps modulo N_SRC. On each RETURN, rr_ptr ← (sel + 1) mod N_SRC.
- Undefined: fixed priority; the lowest index wins. rr_ptr is absent.

Decomposition:
- Package irq_sb_ctrl_pkg holds:
  - register address localparams (MASK/PENDING/ACTIVE/RESET);
  - CAUSE_BASE = 32'h8000_0010;
  - SOFT_RST_KEY = 32'h1;
  - state enum {IDLE, ACTIVE, RETURN}.
- Sub-module irq_prio_enc: combinational. Inputs are the pending vector and the start pointer; outputs are valid and idx. It serves both fixed priority (pointer tied to 0) and rotating priority.

Test Plan:
- Reset, then read 0x00 → read_data_o = 32'h0000_000F one cycle later; core_irq_o = 0.
- src_irq_i = 4'b0100 → next cycle core_irq_o = 1, core_cause_o = 32'h8000_0012. Then core_irq_ret_i pulse → next cycle src_ret_o = 4'b0100 for one cycle, core_irq_o = 0.
- src_irq_i = 4'b1010 simultaneously → fixed mode serves sel 1 first, then 3. Round-robin mode with rr_ptr = 2 serves 3 first.
- Write MASK = 32'h0000_0001 with src_irq_i = 4'b0010 → core_irq_o stays 0 and PENDING reads 0. Then write MASK = 32'h3 → core_irq_o = 1 with cause 32'h8000_0011.
- While ACTIVE on sel 0, write 0x24 with 32'h1 → next cycle core_irq_o = 0, no src_ret_o pulse, MASK = 32'hF. Writing 32'h2 to 0x24 has no effect.
- ACTIVE on sel 2, source drops its request, and src_irq_i[0] rises → no preemption. The return pulse still goes to bit 2, and sel 0 is served on the next IDLE.

Source files
------------

// File: rtl/irq_sb_ctrl_pkg.sv
// Shared constants and types for the shared-line interrupt controller.
// Register word addresses, cause encoding, soft-reset key and FSM states.
package irq_sb_ctrl_pkg;

  localparam int SEL_W = 4;

  localparam logic [31:0] ADDR_MASK    = 32'h0000_0000;
  localparam logic [31:0] ADDR_PENDING = 32'h0000_0004;
  localparam logic [31:0] ADDR_ACTIVE  = 32'h0000_0008;
  localparam logic [31:0] ADDR_RESET   = 32'h0000_0024;

  localparam logic [31:0] CAUSE_BASE   = 32'h8000_0010;
  localparam logic [31:0] SOFT_RST_KEY = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RETURN
  } state_e;

endpackage

// File: rtl/irq_sb_ctrl_prio_enc.sv
// Combinational priority encoder: first pending source at or after start_i,
// wrapping modulo N_SRC. Tie start_i to zero for plain fixed priority.
module irq_prio_enc
  import irq_sb_ctrl_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] pend_i,
  input  logic [SEL_W-1:0] start_i,
  output logic             valid_o,
  output logic [SEL_W-1:0] idx_o
);

  logic [N_SRC-1:0] rot;
  logic [SEL_W-1:0] off;
  logic [SEL_W:0]   sum;

  always_comb begin
    // Rotate so that the start position lands at bit 0, then take the lowest set bit.
    rot     = N_SRC'({pend_i, pend_i} >> start_i);
    valid_o = 1'b0;
    off     = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid_o = 1'b1;
        off     = SEL_W'(i);
      end
    end
    sum = {1'b0, start_i} + {1'b0, off};
    if (sum >= (SEL_W + 1)'(N_SRC)) begin
      sum = sum - (SEL_W + 1)'(N_SRC);
    end
    idx_o = sum[SEL_W-1:0];
  end

endmodule

// File: rtl/irq_sb_ctrl.sv
// Shares the core interrupt line among N_SRC level-triggered peripherals.
// Define IRQ_SB_CTRL_ROUND_ROBIN_EN for rotating priority; default is fixed priority.
module irq_sb_ctrl
  import irq_sb_ctrl_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      addr_i,
  input  logic             req_i,
  input  logic [31:0]      write_data_i,
  input  logic             write_enable_i,
  output logic [31:0]      read_data_o,
  input  logic [N_SRC-1:0] src_irq_i,
  output logic [N_SRC-1:0] src_ret_o,
  output logic             core_irq_o,
  input  logic             core_irq_ret_i,
  output logic [31:0]      core_cause_o
);

  state_e           state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] src_ret_q, src_ret_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             core_irq_q, core_irq_d;
  logic [31:0]      cause_q, cause_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [N_SRC-1:0] pending;
  logic             bus_wr, bus_rd, soft_rst;
  logic             enc_valid;
  logic [SEL_W-1:0] enc_idx, start_ptr;

`ifdef IRQ_SB_CTRL_ROUND_ROBIN_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  assign start_ptr = rr_ptr_q;
`else
  assign start_ptr = '0;
`endif

  assign pending  = src_irq_i & mask_q;
  assign bus_wr   = req_i & write_enable_i;
  assign bus_rd   = req_i & ~write_enable_i;
  assign soft_rst = bus_wr && (addr_i == ADDR_RESET) && (write_data_i == SOFT_RST_KEY);

  irq_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .pend_i  (pending),
    .start_i (start_ptr),
    .valid_o (enc_valid),
    .idx_o   (enc_idx)
  );

  // Soft reset shares the synchronous reset path so both leave identical state.
  always_ff @(posedge clk_i) begin
    if (rst_i || soft_rst) begin
      state_q    <= IDLE;
      mask_q     <= '1;
      src_ret_q  <= '0;
      sel_q      <= '0;
      core_irq_q <= 1'b0;
      cause_q    <= '0;
      rdata_q    <= '0;
`ifdef IRQ_SB_CTRL_ROUND_ROBIN_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      src_ret_q  <= src_ret_d;
      sel_q      <= sel_d;
      core_irq_q <= core_irq_d;
      cause_q    <= cause_d;
      rdata_q    <= rdata_d;
`ifdef IRQ_SB_CTRL_ROUND_ROBIN_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    mask_d  = mask_q;
    rdata_d = rdata_q;
    if (bus_wr && (addr_i == ADDR_MASK)) begin
      mask_d = write_data_i[N_SRC-1:0];
    end
    if (bus_rd) begin
      case (addr_i)
        ADDR_MASK:    rdata_d = 32'(mask_q);
        ADDR_PENDING: rdata_d = 32'(pending);
        ADDR_ACTIVE:  rdata_d = {(state_q == ACTIVE), {(31 - SEL_W){1'b0}}, sel_q};
        default:      rdata_d = rdata_q;
      endcase
    end
  end

  // Arbitration happens only in IDLE; sel is frozen until the handshake completes.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
`ifdef IRQ_SB_CTRL_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (enc_valid) begin
          state_d = ACTIVE;
          sel_d   = enc_idx;
        end
      end
      ACTIVE: begin
        if (core_irq_ret_i) begin
          state_d = RETURN;
`ifdef IRQ_SB_CTRL_ROUND_ROBIN_EN
          rr_ptr_d = (sel_q == SEL_W'(N_SRC - 1)) ? '0 : sel_q + 1'b1;
`endif
        end
      end
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_irq_d = (state_d == ACTIVE);
    cause_d    = core_irq_d ? (CAUSE_BASE | 32'(sel_d)) : '0;
    src_ret_d  = '0;
    if (state_d == RETURN) begin
      src_ret_d = N_SRC'(1) << sel_q;
    end
  end

  assign read_data_o  = rdata_q;
  assign src_ret_o    = src_ret_q;
  assign core_irq_o   = core_irq_q;
  assign core_cause_o = cause_q;

endmodule

// File: tb/tb_irq_sb_ctrl.sv
// Self-checking bench for irq_sb_ctrl: vector table plus hand-written handshake sequences.
// Expected return pulses and read data flow through scoreboard queues.
module tb_irq_sb_ctrl;

  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic         req_i;
  logic [31:0]  write_data_i;
  logic         write_enable_i;
  logic [31:0]  read_data_o;
  logic [N-1:0] src_irq_i;
  logic [N-1:0] src_ret_o;
  logic         core_irq_o;
  logic         core_irq_ret_i;
  logic [31:0]  core_cause_o;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  bit mon_en = 1'b0;

  logic [N-1:0] ret_q[$];
  logic [31:0]  rd_q[$];

  typedef struct {
    logic [3:0] mask;
    logic [3:0] src;
    logic       exp_irq;
    int         exp_sel;
  } vec_t;

  vec_t vecs[8];

  irq_sb_ctrl #(
    .N_SRC (N)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .addr_i         (addr_i),
    .req_i          (req_i),
    .write_data_i   (write_data_i),
    .write_enable_i (write_enable_i),
    .read_data_o    (read_data_o),
    .src_irq_i      (src_irq_i),
    .src_ret_o      (src_ret_o),
    .core_irq_o     (core_irq_o),
    .core_irq_ret_i (core_irq_ret_i),
    .core_cause_o   (core_cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    req_i          = 1'b1;
    write_enable_i = 1'b1;
    addr_i         = a;
    write_data_i   = d;
    step();
    req_i          = 1'b0;
    write_enable_i = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    req_i          = 1'b1;
    write_enable_i = 1'b0;
    addr_i         = a;
    rd_q.push_back(exp);
    step();
    req_i = 1'b0;
    check(name, read_data_o, rd_q.pop_front());
  endtask

  // Reference arbiter: linear search from ptr, wrapping modulo N.
  function automatic int pick(input logic [3:0] pend, input int ptr);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (pend[j[1:0]]) return j;
    end
    return -1;
  endfunction

  // Caller is in ACTIVE on sel; finishes the handshake and lands one cycle into IDLE.
  task automatic serve(input string name, input int sel, input logic [3:0] src_after);
    check({name, "_cause"}, core_cause_o, 32'h8000_0010 | 32'(sel));
    core_irq_ret_i = 1'b1;
    ret_q.push_back(4'b0001 << sel);
    step();
    core_irq_ret_i = 1'b0;
    src_irq_i      = src_after;
    check({name, "_irq_in_return"}, 32'(core_irq_o), 32'h0);
    check({name, "_cause_in_return"}, core_cause_o, 32'h0);
    step();
    check({name, "_ret_one_cycle"}, 32'(src_ret_o), 32'h0);
`ifdef IRQ_SB_CTRL_ROUND_ROBIN_EN
    exp_ptr = (sel + 1) % N;
`endif
  endtask

  always @(negedge clk_i) begin
    if (mon_en && (src_ret_o !== '0)) begin
      if (ret_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL src_ret_unexpected: got %b, required 0000", src_ret_o);
      end else begin
        check("src_ret", 32'(src_ret_o), 32'(ret_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, s1, s2;
    logic [3:0] rem;

    vecs[0] = '{mask: 4'hF, src: 4'b0100, exp_irq: 1'b1, exp_sel: 2};
    vecs[1] = '{mask: 4'hF, src: 4'b0001, exp_irq: 1'b1, exp_sel: 0};
    vecs[2] = '{mask: 4'hF, src: 4'b1000, exp_irq: 1'b1, exp_sel: 3};
    vecs[3] = '{mask: 4'hF, src: 4'b0110, exp_irq: 1'b1, exp_sel: 1};
    vecs[4] = '{mask: 4'h1, src: 4'b0010, exp_irq: 1'b0, exp_sel: 0};
    vecs[5] = '{mask: 4'hC, src: 4'b1111, exp_irq: 1'b1, exp_sel: 2};
    vecs[6] = '{mask: 4'h0, src: 4'b1111, exp_irq: 1'b0, exp_sel: 0};
    vecs[7] = '{mask: 4'hA, src: 4'b1011, exp_irq: 1'b1, exp_sel: 1};

    rst_i          = 1'b1;
    req_i          = 1'b0;
    write_enable_i = 1'b0;
    addr_i         = '0;
    write_data_i   = '0;
    src_irq_i      = '0;
    core_irq_ret_i = 1'b0;
    step();
    step();
    rst_i  = 1'b0;
    mon_en = 1'b1;

    check("rst_read_data", read_data_o, 32'h0);
    check("rst_core_irq", 32'(core_irq_o), 32'h0);
    check("rst_cause", core_cause_o, 32'h0);
    check("rst_src_ret", 32'(src_ret_o), 32'h0);
    bus_read("rst_mask", 32'h00, 32'h0000_000F);
    check("rst_core_irq_after_read", 32'(core_irq_o), 32'h0);

    core_irq_ret_i = 1'b1;
    step();
    core_irq_ret_i = 1'b0;
    check("ret_in_idle_irq", 32'(core_irq_o), 32'h0);
    step();
    check("ret_in_idle_no_pulse", 32'(src_ret_o), 32'h0);

    for (int i = 0; i < 8; i++) begin
      bus_write(32'h00, 32'(vecs[i].mask));
      src_irq_i = vecs[i].src;
      step();
      check($sformatf("vec%0d_irq", i), 32'(core_irq_o), 32'(vecs[i].exp_irq));
      if (vecs[i].exp_irq) begin
`ifdef IRQ_SB_CTRL_ROUND_ROBIN_EN
        s = pick(vecs[i].src & vecs[i].mask, exp_ptr);
`else
        s = vecs[i].exp_sel;
`endif
        bus_read($sformatf("vec%0d_active", i), 32'h08, 32'h8000_0000 | 32'(s));
        serve($sformatf("vec%0d", i), s, 4'b0000);
      end else begin
        bus_read($sformatf("vec%0d_pending", i), 32'h04, 32'(vecs[i].src & vecs[i].mask));
        src_irq_i = '0;
        step();
      end
    end
    bus_write(32'h00, 32'h0000_000F);

    src_irq_i = 4'b1010;
    step();
    check("simul_irq1", 32'(core_irq_o), 32'h1);
    s1  = pick(4'b1010, exp_ptr);
    rem = 4'b1010 & ~(4'b0001 << s1);
    serve("simul1", s1, rem);
    check("simul_no_rearb_in_return", 32'(core_irq_o), 32'h0);
    step();
    check("simul_irq2", 32'(core_irq_o), 32'h1);
    s2 = pick(rem, exp_ptr);
    serve("simul2", s2, 4'b0000);
    step();

    bus_write(32'h00, 32'h0000_0001);
    src_irq_i = 4'b0010;
    step();
    step();
    check("masked_irq", 32'(core_irq_o), 32'h0);
    bus_read("masked_pending", 32'h04, 32'h0);
    bus_write(32'h00, 32'h0000_0003);
    check("mask_write_edge_irq", 32'(core_irq_o), 32'h0);
    step();
    check("unmasked_irq", 32'(core_irq_o), 32'h1);
    serve("unmasked", pick(4'b0010, exp_ptr), 4'b0000);
    step();
    bus_write(32'h00, 32'h0000_000F);

    src_irq_i = 4'b0001;
    step();
    check("softrst_pre_irq", 32'(core_irq_o), 32'h1);
    bus_write(32'h24, 32'h0000_0001);
    src_irq_i = 4'b0000;
    exp_ptr   = 0;
    check("softrst_irq", 32'(core_irq_o), 32'h0);
    check("softrst_cause", core_cause_o, 32'h0);
    step();
    check("softrst_no_pulse", 32'(src_ret_o), 32'h0);
    bus_read("softrst_mask", 32'h00, 32'h0000_000F);
    bus_write(32'h00, 32'h0000_0005);
    bus_write(32'h24, 32'h0000_0002);
    bus_read("bad_key_mask", 32'h00, 32'h0000_0005);
    bus_write(32'h00, 32'h0000_000F);

    src_irq_i = 4'b1000;
    step();
    check("hwrst_pre_irq", 32'(core_irq_o), 32'h1);
    rst_i = 1'b1;
    step();
    rst_i     = 1'b0;
    src_irq_i = 4'b0000;
    exp_ptr   = 0;
    check("hwrst_irq", 32'(core_irq_o), 32'h0);
    step();

    src_irq_i = 4'b0100;
    step();
    check("drop_irq", 32'(core_irq_o), 32'h1);
    src_irq_i = 4'b0001;
    step();
    step();
    check("nopreempt_irq", 32'(core_irq_o), 32'h1);
    bus_read("nopreempt_active", 32'h08, 32'h8000_0002);
    serve("nopreempt", 2, 4'b0001);
    step();
    check("after_irq", 32'(core_irq_o), 32'h1);
    serve("after", pick(4'b0001, exp_ptr), 4'b0000);
    step();

    check("ret_queue_drained", 32'(ret_q.size()), 32'h0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
